// File: rtl/spi_slave.sv
// SPI responder: oversamples the SPI pins on clk, receives MSB-first words into
// bus_data_out and shifts bus_data_in out on spi_miso, in any of the four SPI modes.
module spi_slave #(
  parameter int cpol       = 0,
  parameter int cpha       = 0,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_cs,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [data_width-1:0] bus_data_in,
  output logic [data_width-1:0] bus_data_out,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_abort
);

  localparam int CNT_W = $clog2(data_width + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(data_width - 1);
  localparam logic [CNT_W-1:0] WORD_DONE = CNT_W'(data_width);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [data_width-1:0] tx_q, tx_d;
  logic [data_width-2:0] rx_q, rx_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  miso_q, miso_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  abort_q, abort_d;

  logic [2:0]            cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                  sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                  sample_edge, shift_edge, cs_rise, cs_fall, mosi_bit;
  logic                  word_end, partial;
  logic [data_width-1:0] rx_shift;

  // Index 1 is the second synchroniser stage, index 2 the history flop.
  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
  assign lead_edge   = (cpol == 0) ? sclk_rise : sclk_fall;
  assign trail_edge  = (cpol == 0) ? sclk_fall : sclk_rise;
  assign sample_edge = (cpha == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (cpha == 0) ? trail_edge : lead_edge;
  // MOSI taken one flop later than the SCLK edge; it has been stable for a half period.
  assign mosi_bit    = mosi_sync_q[2];
  assign rx_shift    = {rx_q, mosi_bit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    dout_d     = dout_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
    word_end   = 1'b0;
    partial    = 1'b0;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          tx_d    = bus_data_in;
          if (cpha == 0) miso_d = bus_data_in[data_width-1];
        end
      end
      ACTIVE: begin
        if (cnt_q == WORD_DONE) begin
          // Word boundary: reload here so bus_data_in may change during rx_valid.
          cnt_d = '0;
          tx_d  = bus_data_in;
          if (cpha == 0) miso_d = bus_data_in[data_width-1];
        end else if (sample_edge) begin
          rx_d  = rx_shift[data_width-2:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            dout_d     = rx_shift;
            rx_valid_d = 1'b1;
            word_end   = 1'b1;
          end
        end else if (shift_edge) begin
          if (cpha == 0) begin
            // A trailing edge at count 0 is the last one of the previous word.
            if (cnt_q != '0) begin
              tx_d   = tx_q << 1;
              miso_d = tx_q[data_width-2];
            end
          end else if (cnt_q == '0) begin
            miso_d = tx_q[data_width-1];
          end else begin
            tx_d   = tx_q << 1;
            miso_d = tx_q[data_width-2];
          end
        end
        partial = !word_end && (sample_edge || (cnt_q != '0 && cnt_q != WORD_DONE));
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
          abort_d = partial;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    cs_sync_q   <= {cs_sync_q[1:0], spi_cs};
    sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
    mosi_sync_q <= {mosi_sync_q[1:0], spi_mosi};
    tx_q        <= tx_d;
    rx_q        <= rx_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
      dout_q     <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      dout_q     <= dout_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
    end
  end

  assign spi_miso     = miso_q;
  assign bus_data_out = dout_q;
  assign rx_valid     = rx_valid_q;
  assign frame_abort  = abort_q;
  assign busy         = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master per instance, with a word-level
// expectation model (slave receives what the master sent, master receives bus_data_in).
module tb_spi_slave;

  localparam int H  = 5;
  localparam int NI = 4;
  localparam int CPOL_A [NI] = '{1, 0, 0, 0};
  localparam int CPHA_A [NI] = '{1, 0, 1, 1};
  localparam int WID_A  [NI] = '{8, 8, 8, 16};

  logic            clk = 1'b0;
  logic            reset;
  logic [NI-1:0]   cs_v, sclk_v, mosi_v, miso_v, valid_v, busy_v, abort_v;
  logic [2:0][7:0] din8, dout8;
  logic [15:0]     din16, dout16;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] rxq [NI][$];
  int          abort_cnt [NI] = '{default: 0};
  logic        busy_bad;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut8
    spi_slave #(.cpol(CPOL_A[g]), .cpha(CPHA_A[g]), .data_width(8)) u_dut (
      .clk(clk), .reset(reset), .spi_cs(cs_v[g]), .spi_sclk(sclk_v[g]),
      .spi_mosi(mosi_v[g]), .spi_miso(miso_v[g]), .bus_data_in(din8[g]),
      .bus_data_out(dout8[g]), .rx_valid(valid_v[g]), .busy(busy_v[g]),
      .frame_abort(abort_v[g]));
  end

  spi_slave #(.cpol(0), .cpha(1), .data_width(16)) u_dut16 (
    .clk(clk), .reset(reset), .spi_cs(cs_v[3]), .spi_sclk(sclk_v[3]),
    .spi_mosi(mosi_v[3]), .spi_miso(miso_v[3]), .bus_data_in(din16),
    .bus_data_out(dout16), .rx_valid(valid_v[3]), .busy(busy_v[3]),
    .frame_abort(abort_v[3]));

  function automatic logic [15:0] get_dout(input int i);
    case (i)
      0:       return {8'h00, dout8[0]};
      1:       return {8'h00, dout8[1]};
      2:       return {8'h00, dout8[2]};
      default: return dout16;
    endcase
  endfunction

  function automatic logic [15:0] wmask(input int i);
    return (WID_A[i] == 16) ? 16'hFFFF : 16'h00FF;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (valid_v[i]) rxq[i].push_back(get_dout(i));
      if (abort_v[i]) abort_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_din(input int i, input logic [15:0] v);
    case (i)
      0:       din8[0] = v[7:0];
      1:       din8[1] = v[7:0];
      2:       din8[2] = v[7:0];
      default: din16 = v;
    endcase
  endtask

  // Master side: nbits SCLK cycles, MSB first, in the instance's mode.
  task automatic xfer_bits(input int idx, input logic [15:0] tx, input int nbits,
                           output logic [15:0] rx);
    int   w;
    logic lead, idle;
    w    = WID_A[idx];
    lead = (CPOL_A[idx] == 0);
    idle = ~lead;
    rx   = '0;
    mosi_v[idx] = tx[w-1];
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      if (CPHA_A[idx] == 0) begin
        rx = {rx[14:0], miso_v[idx]};
        sclk_v[idx] = lead;
        wait_clk(H);
        if (!busy_v[idx]) busy_bad = 1'b1;
        sclk_v[idx] = idle;
        if (i + 1 < nbits) mosi_v[idx] = tx[w-2-i];
        wait_clk(H);
      end else begin
        sclk_v[idx] = lead;
        mosi_v[idx] = tx[w-1-i];
        wait_clk(H);
        if (!busy_v[idx]) busy_bad = 1'b1;
        rx = {rx[14:0], miso_v[idx]};
        sclk_v[idx] = idle;
        wait_clk(H);
      end
    end
  endtask

  task automatic run_frame(input int idx, input int nw, input logic [15:0] w0, w1,
                           output logic [15:0] r0, r1);
    check($sformatf("busy_before[%0d]", idx), busy_v[idx], 1'b0);
    busy_bad = 1'b0;
    cs_v[idx] = 1'b0;
    xfer_bits(idx, w0, WID_A[idx], r0);
    r1 = '0;
    if (nw > 1) xfer_bits(idx, w1, WID_A[idx], r1);
    cs_v[idx] = 1'b1;
    wait_clk(2 * H);
    check($sformatf("busy_frame[%0d]", idx), busy_bad, 1'b0);
    check($sformatf("busy_after[%0d]", idx), busy_v[idx], 1'b0);
  endtask

  task automatic expect_rx(input int idx, input int n, input logic [15:0] e0, e1);
    check($sformatf("rx_count[%0d]", idx), rxq[idx].size(), n);
    if (n > 0 && rxq[idx].size() > 0) check($sformatf("rx_word0[%0d]", idx), rxq[idx].pop_front(), e0);
    if (n > 1 && rxq[idx].size() > 0) check($sformatf("rx_word1[%0d]", idx), rxq[idx].pop_front(), e1);
    rxq[idx].delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r0, r1, w0, w1, d;
    logic        seen;
    int          base, nw;
    reset  = 1'b1;
    cs_v   = '1;
    mosi_v = '0;
    din8   = '0;
    din16  = '0;
    for (int i = 0; i < NI; i++) sclk_v[i] = (CPOL_A[i] != 0);
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_miso[%0d]", i), miso_v[i], 1'b0);
      check($sformatf("rst_busy[%0d]", i), busy_v[i], 1'b0);
      check($sformatf("rst_dout[%0d]", i), get_dout(i), 16'h0);
      check($sformatf("rst_valid_abort[%0d]", i), {valid_v[i], abort_v[i]}, 2'b00);
    end

    // Mode 3 single word
    set_din(0, 16'h78);
    run_frame(0, 1, 16'hFA, 16'h0, r0, r1);
    check("m3_master_rx", r0, 16'h78);
    expect_rx(0, 1, 16'hFA, 16'h0);
    check("m3_dout", get_dout(0), 16'hFA);

    // Mode 0 single word, MSB presented before the first SCLK edge
    set_din(1, 16'h3C);
    cs_v[1] = 1'b0;
    wait_clk(4);
    check("m0_miso_pre", miso_v[1], 1'b0);
    xfer_bits(1, 16'hA5, 8, r0);
    cs_v[1] = 1'b1;
    wait_clk(2 * H);
    check("m0_master_rx", r0, 16'h3C);
    expect_rx(1, 1, 16'hA5, 16'h0);
    check("m0_dout", get_dout(1), 16'hA5);

    // Mode 3 back-to-back; bus_data_in changes in the first rx_valid cycle
    set_din(0, 16'h11);
    seen = 1'b0;
    fork
      run_frame(0, 2, 16'h0F, 16'hF0, r0, r1);
      begin
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          if (valid_v[0]) begin
            set_din(0, 16'h22);
            seen = 1'b1;
          end
        end
      end
    join
    check("b2b_valid_seen", seen, 1'b1);
    check("b2b_master_rx0", r0, 16'h11);
    check("b2b_master_rx1", r1, 16'h22);
    expect_rx(0, 2, 16'h0F, 16'hF0);

    // Mode 0 abort after 3 bits of 0xFF, then a clean 0x5A frame
    base = abort_cnt[1];
    cs_v[1] = 1'b0;
    xfer_bits(1, 16'hFF, 3, r0);
    cs_v[1] = 1'b1;
    wait_clk(2 * H);
    check("abort_pulses", abort_cnt[1] - base, 1);
    expect_rx(1, 0, 16'h0, 16'h0);
    check("abort_dout_held", get_dout(1), 16'hA5);
    set_din(1, 16'h96);
    run_frame(1, 1, 16'h5A, 16'h0, r0, r1);
    check("post_abort_master_rx", r0, 16'h96);
    expect_rx(1, 1, 16'h5A, 16'h0);

    // Width 16, mode 1
    set_din(3, 16'h1234);
    run_frame(3, 1, 16'hBEEF, 16'h0, r0, r1);
    check("w16_master_rx", r0, 16'h1234);
    expect_rx(3, 1, 16'hBEEF, 16'h0);
    check("w16_dout", get_dout(3), 16'hBEEF);

    // Randomized frames on every instance
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 5; n++) begin
        nw = $urandom_range(1, 2);
        w0 = 16'($urandom) & wmask(i);
        w1 = 16'($urandom) & wmask(i);
        d  = 16'($urandom) & wmask(i);
        set_din(i, d);
        base = abort_cnt[i];
        run_frame(i, nw, w0, w1, r0, r1);
        check($sformatf("rnd_master_rx0[%0d]", i), r0, d);
        if (nw > 1) check($sformatf("rnd_master_rx1[%0d]", i), r1, d);
        expect_rx(i, nw, w0, w1);
        check($sformatf("rnd_dout[%0d]", i), get_dout(i), (nw > 1) ? w1 : w0);
        check($sformatf("rnd_no_abort[%0d]", i), abort_cnt[i] - base, 0);
      end
    end

    // Mode 1 reset after 4 bits with CS held low
    set_din(2, 16'h5C);
    base = abort_cnt[2];
    cs_v[2] = 1'b0;
    xfer_bits(2, 16'hA0, 4, r0);
    reset = 1'b1;
    wait_clk(2);
    check("rst_mid_miso", miso_v[2], 1'b0);
    check("rst_mid_busy", busy_v[2], 1'b0);
    check("rst_mid_dout", get_dout(2), 16'h0);
    check("rst_mid_valid_abort", {valid_v[2], abort_v[2]}, 2'b00);
    reset = 1'b0;
    xfer_bits(2, 16'h50, 4, r0);
    check("rst_rest_busy", busy_v[2], 1'b0);
    cs_v[2] = 1'b1;
    wait_clk(2 * H);
    expect_rx(2, 0, 16'h0, 16'h0);
    check("rst_rest_no_abort", abort_cnt[2] - base, 0);
    set_din(2, 16'h3A);
    run_frame(2, 1, 16'hC3, 16'h0, r0, r1);
    check("post_rst_master_rx", r0, 16'h3A);
    expect_rx(2, 1, 16'hC3, 16'h0);
    check("post_rst_dout", get_dout(2), 16'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave (responder) for the far end of our SPI master link.
- Oversamples spi_sclk, spi_cs and spi_mosi on the system clock, so it needs no second clock domain.
- Shifts received MOSI bits into a word and presents it on bus_data_out with a one-cycle rx_valid strobe.
- Shifts bus_data_in out on spi_miso, MSB first, in any of the four SPI modes.

Parameters:
- cpol, 0: idle level of spi_sclk.
- cpha, 0: 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- data_width, 8: bits per word.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- spi_cs  input  1  chip select, active low, asynchronous to clk.
- spi_sclk  input  1  serial clock from the master, asynchronous to clk.
- spi_mosi  input  1  serial data from the master.
- spi_miso  output  1  serial data to the master.
- bus_data_in  input  data_width  word to transmit; latched at frame start and at each word boundary.
- bus_data_out  output  data_width  last complete received word.
- rx_valid  output  1  one-cycle pulse when bus_data_out is updated.
- busy  output  1  high while a frame is active.
- frame_abort  output  1  one-cycle pulse when CS deasserts mid-word.

Behaviour:
- Clocking constraint: spi_sclk half-period must be at least 4 clk periods.
- Input synchronisation:
  - spi_cs, spi_sclk and spi_mosi each pass through a 2-flop synchroniser plus one history flop.
  - Edges are detected by comparing stage 2 against stage 3.
  - An edge is therefore detected 2-3 clk after the pin transition.
- Edge definitions:
  - Leading edge = spi_sclk transition from cpol to ~cpol; trailing edge = the reverse.
  - cpha=0: sample on leading, shift on trailing. cpha=1: shift on leading, sample on trailing.
- Reset values: spi_miso=0, bus_data_out=0, rx_valid=0, busy=0, frame_abort=0, bit counter=0, FSM in IDLE.
  - Reset overrides everything, including a frame in progress.
  - After reset the block waits for a fresh CS falling edge; a CS already low at reset release is ignored until it rises and falls again.
- State machine:
  - IDLE:
    - spi_miso=0, busy=0.
    - On a synchronised CS falling edge: load tx shift register from bus_data_in, clear bit counter, go to ACTIVE.
    - If cpha=0, drive bus_data_in MSB onto spi_miso in the same cycle.
  - ACTIVE:
    - busy=1.
    - On each sample edge: shift the synchronised MOSI into the rx shift register LSB, increment the bit counter.
    - On each shift edge: shift tx left and put the new MSB on spi_miso.
      - cpha=1: the first leading edge presents the original MSB, with no shift beforehand.
      - cpha=0: the final trailing edge of a word is absorbed by the reload below.
    - When the counter reaches data_width on a sample edge:
      - Next cycle: bus_data_out <= rx word, rx_valid=1 for exactly one cycle, counter <= 0.
      - Reload tx from bus_data_in in that same cycle, so back-to-back words under one CS are supported.
      - For cpha=0 the new MSB appears on spi_miso at the reload.
    - On a CS rising edge with counter=0: go to IDLE quietly.
    - On a CS rising edge with counter≠0: pulse frame_abort one cycle, discard the partial word (bus_data_out unchanged, no rx_valid), go to IDLE.
- Simultaneous events:
  - A CS rising edge detected in the same cycle as the final sample edge completes the word (rx_valid fires), then returns to IDLE.
  - SCLK edges are ignored while CS is high.
- Bit order: MSB first in both directions.
- rx_valid to bus_data_out timing: bus_data_out is stable in the rx_valid cycle and held until the next word completes.

Test Plan:
- cpol=1, cpha=1, width 8, master divider 10: master sends 0xFA, slave bus_data_in=0x78 -> master receives 0x78, bus_data_out=0xFA, exactly one rx_valid pulse, busy high for the whole frame only.
- cpol=0, cpha=0: master sends 0xA5, bus_data_in=0x3C -> spi_miso shows 0 (MSB of 0x3C) before the first SCLK edge; master receives 0x3C; bus_data_out=0xA5.
- Back-to-back, one CS, mode 3:
  - Master sends 0x0F then 0xF0; bus_data_in changed 0x11->0x22 in the first rx_valid cycle.
  - Required: two rx_valid pulses with 0x0F then 0xF0; master receives 0x11 then 0x22.
- Abort, mode 0: CS deasserted after 3 SCLK cycles of 0xFF.
  - Required: frame_abort pulses once, no rx_valid, bus_data_out keeps its old value.
  - A following 0x5A frame is received correctly.
- Reset mid-frame, mode 1: assert reset for 2 clk after 4 bits with CS still low.
  - Required: all outputs at reset values.
  - The remainder of that frame produces no rx_valid.
  - Next CS frame 0xC3 is received correctly.
- Width 16, cpol=0, cpha=1: master sends 0xBEEF, bus_data_in=0x1234 -> bus_data_out=0xBEEF, master receives 0x1234.
